// File: rtl/flp_pkg.sv
// Shared FLP datapath package.
// Holds the shift-amount width helper and the mapping of logarithmic
// shifter levels onto pipeline stages. Level k goes to stage
// floor(k*stages/shw). Every stage receives at least one level as long as
// stages <= shw.
package flp_pkg;

    // Width needed to express a shift amount of 0..width inclusive.
    function automatic int shw_of(input int width);
        return $clog2(width + 1);
    endfunction

    // Pipeline stage that hosts shifter level lvl.
    function automatic int lvl_stage(input int lvl, input int stages, input int shw);
        return (lvl * stages) / shw;
    endfunction

    // Index of the first level handled by stage 'stage'.
    function automatic int first_lvl(input int stage, input int stages, input int shw);
        int n;
        n = 0;
        for (int k = 0; k < shw; k++) begin
            if (lvl_stage(k, stages, shw) < stage) n++;
        end
        return n;
    endfunction

    // Number of levels handled by stage 'stage'.
    function automatic int num_lvl(input int stage, input int stages, input int shw);
        int n;
        n = 0;
        for (int k = 0; k < shw; k++) begin
            if (lvl_stage(k, stages, shw) == stage) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/flp_vshrjam_stage.sv
// Combinational group of logarithmic right-shift levels.
// Covers levels FIRST_LVL .. FIRST_LVL+NUM_LVL-1. Level k shifts by 2^k when
// shamt_in[k] is set, and every bit it pushes below bit 0 is ORed into the
// running sticky.
//   d_in / d_out         : operand before / after this group of levels
//   shamt_in / shamt_out : full shift amount, passed through unchanged
//   sticky_in / sticky_out : running OR of all bits shifted out so far
module flp_vshrjam_stage #(
    parameter int INWIDTH   = 64,
    parameter int SHW       = 7,
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 1
) (
    input  logic [INWIDTH-1:0] d_in,
    input  logic [SHW-1:0]     shamt_in,
    input  logic               sticky_in,
    output logic [INWIDTH-1:0] d_out,
    output logic [SHW-1:0]     shamt_out,
    output logic               sticky_out
);

    localparam logic [INWIDTH-1:0] ONES = '1;

    // NOTE: d_out/sticky_out get a default first so no path leaves them
    // unassigned (no latch), and are then updated level by level with
    // blocking assignments so each level sees the previous level's result.
    always_comb begin
        d_out      = d_in;
        sticky_out = sticky_in;
        for (int j = 0; j < NUM_LVL; j++) begin
            if (shamt_in[FIRST_LVL + j]) begin
                // A shift of 2^k >= INWIDTH pushes every bit out: the mask
                // becomes all ones and the data becomes zero.
                sticky_out = sticky_out | (|(d_out & ~(ONES << (1 << (FIRST_LVL + j)))));
                d_out      = d_out >> (1 << (FIRST_LVL + j));
            end
        end
    end

    assign shamt_out = shamt_in;

endmodule

// File: rtl/flp_vshrjam_pipe.sv
// Pipelined variable shift-right-and-jam unit.
// Splits a logarithmic shifter across STAGES register stages. The stages
// are joined by a bubble-collapsing valid/ready chain. The final truncation
// to OUTWIDTH and the jam of sticky into the LSB are applied on the output
// side of the last register.
//   clk, nrst             : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake
//   in_data, in_shamt     : operand and right-shift amount
//   in_jam                : OR sticky into the result LSB
//   out_valid/out_ready   : output handshake
//   out_data, out_sticky  : truncated (optionally jammed) result, sticky
module flp_vshrjam_pipe
    import flp_pkg::*;
#(
    parameter int  INWIDTH  = 64,
    parameter int  OUTWIDTH = 32,
    parameter int  STAGES   = 2,
    localparam int SHW      = shw_of(INWIDTH)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INWIDTH-1:0]  in_data,
    input  logic [SHW-1:0]      in_shamt,
    input  logic                in_jam,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTWIDTH-1:0] out_data,
    output logic                out_sticky
);

    logic [STAGES-1:0]  v_q;
    logic [STAGES:0]    load_en;
    logic [INWIDTH-1:0] d_q   [STAGES];
    logic [SHW-1:0]     sa_q  [STAGES];
    logic [STAGES-1:0]  st_q;
    logic [STAGES-1:0]  jam_q;

    logic [INWIDTH-1:0] src_d  [STAGES];
    logic [SHW-1:0]     src_sa [STAGES];
    logic [STAGES-1:0]  src_st;
    logic [STAGES-1:0]  src_jam;
    logic [STAGES-1:0]  src_v;
    logic [INWIDTH-1:0] nxt_d  [STAGES];
    logic [SHW-1:0]     nxt_sa [STAGES];
    logic [STAGES-1:0]  nxt_st;

    // A stage loads when it is empty or when its successor takes its
    // content this cycle. The slot past the last stage is the consumer.
    assign load_en[STAGES] = out_ready;
    assign in_ready        = load_en[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign src_d[i]   = in_data;
            assign src_sa[i]  = in_shamt;
            assign src_st[i]  = 1'b0;
            assign src_jam[i] = in_jam;
            assign src_v[i]   = in_valid;
        end else begin : g_body
            assign src_d[i]   = d_q[i-1];
            assign src_sa[i]  = sa_q[i-1];
            assign src_st[i]  = st_q[i-1];
            assign src_jam[i] = jam_q[i-1];
            assign src_v[i]   = v_q[i-1];
        end

        assign load_en[i] = !v_q[i] || load_en[i+1];

        flp_vshrjam_stage #(
            .INWIDTH   (INWIDTH),
            .SHW       (SHW),
            .FIRST_LVL (first_lvl(i, STAGES, SHW)),
            .NUM_LVL   (num_lvl(i, STAGES, SHW))
        ) u_stage (
            .d_in       (src_d[i]),
            .shamt_in   (src_sa[i]),
            .sticky_in  (src_st[i]),
            .d_out      (nxt_d[i]),
            .shamt_out  (nxt_sa[i]),
            .sticky_out (nxt_st[i])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load_en[i]) v_q[i] <= src_v[i];
            end
        end
    end

    // NOTE: payload registers carry no reset; the valid bits alone decide
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (load_en[i]) begin
                d_q[i]   <= nxt_d[i];
                sa_q[i]  <= nxt_sa[i];
                st_q[i]  <= nxt_st[i];
                jam_q[i] <= src_jam[i];
            end
        end
    end

    // Bits above OUTWIDTH are dropped here and never reach the jam.
    assign out_valid  = v_q[STAGES-1];
    assign out_sticky = st_q[STAGES-1];
    assign out_data   = d_q[STAGES-1][OUTWIDTH-1:0]
                      | OUTWIDTH'(jam_q[STAGES-1] & st_q[STAGES-1]);

    // The last stage's shift amount and upper data bits have no consumer.
    logic unused_tail;
    if (OUTWIDTH < INWIDTH) begin : g_trunc
        assign unused_tail = ^{sa_q[STAGES-1], d_q[STAGES-1][INWIDTH-1:OUTWIDTH]};
    end else begin : g_full
        assign unused_tail = ^sa_q[STAGES-1];
    end

endmodule

// File: tb/tb_flp_vshrjam_pipe.sv
// Self-checking bench for flp_vshrjam_pipe at its default 64/32/2 size.
module tb_flp_vshrjam_pipe;

    localparam int INW = 64;
    localparam int OUTW = 32;
    localparam int STG = 2;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [INW-1:0]  in_data = '0;
    logic [6:0]      in_shamt = '0;
    logic            in_jam = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [OUTW-1:0] out_data;
    logic            out_sticky;

    flp_vshrjam_pipe #(.INWIDTH(INW), .OUTWIDTH(OUTW), .STAGES(STG)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_jam     (in_jam),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INW-1:0]  data;
        logic [6:0]      shamt;
        logic            jam;
        logic [OUTW-1:0] exp_data;
        logic            exp_sticky;
    } vec_t;

    typedef struct {
        logic [OUTW-1:0] d;
        logic            s;
        int              acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_drained = 0;
    bit   check_lat = 0;
    bit   check_rdy = 0;
    bit   held_valid = 0;
    logic [OUTW-1:0] held_data;
    logic            held_sticky;
    logic [OUTW-1:0] cur_exp_d;
    logic            cur_exp_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bitwise definition, independent of the level structure.
    function automatic void model(input logic [INW-1:0] d, input logic [6:0] s, input logic j,
                                  output logic [OUTW-1:0] od, output logic os);
        logic [INW-1:0] full;
        os = 1'b0;
        for (int b = 0; b < INW; b++) begin
            if (b < int'(s)) os = os | d[b];
        end
        full = (int'(s) >= INW) ? '0 : (d >> s);
        od = full[OUTW-1:0];
        od[0] = od[0] | (j & os);
    endfunction

    // Called at a negedge with inputs already driven: evaluates the
    // handshake for the coming edge, then advances to the next negedge.
    task automatic cycle(output bit acc);
        exp_t e;
        bit   drn;
        #1;
        if (held_valid) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_data);
            check("stall_sticky", out_sticky, held_sticky);
        end
        if (check_rdy)
            check("in_ready", in_ready, (sb.size() < STG) || out_ready);
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (out_valid && sb.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
            drn = 0;
        end
        if (drn) begin
            e = sb.pop_front();
            check("out_data", out_data, e.d);
            check("out_sticky", out_sticky, e.s);
            if (check_lat) check("latency", cyc - e.acc_cyc, STG);
            n_drained++;
        end
        if (acc) begin
            e.d = cur_exp_d;
            e.s = cur_exp_s;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        held_valid  = out_valid && !out_ready;
        held_data   = out_data;
        held_sticky = out_sticky;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [INW-1:0] d, input logic [6:0] s, input logic j);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_jam   = j;
        model(d, s, j, cur_exp_d, cur_exp_s);
    endtask

    task automatic drain(input int bound);
        bit dummy;
        for (int t = 0; t < bound && sb.size() > 0; t++) cycle(dummy);
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        bit   got;
        int   idx;
        int   k;
        int   base;
        logic [INW-1:0] bp_d[6];
        logic [6:0]     bp_s[6];

        vecs[0]  = '{64'hF2, 7'd2, 1'b1, 32'h3D, 1'b1};
        vecs[1]  = '{64'hF2, 7'd2, 1'b0, 32'h3C, 1'b1};
        vecs[2]  = '{64'hF4, 7'd2, 1'b1, 32'h3D, 1'b0};
        vecs[3]  = '{64'hFFFF_FFFF_1234_5678, 7'd0, 1'b1, 32'h1234_5678, 1'b0};
        vecs[4]  = '{64'h8000_0000_0000_0000, 7'd32, 1'b1, 32'h8000_0000, 1'b0};
        vecs[5]  = '{64'h1, 7'd64, 1'b1, 32'h1, 1'b1};
        vecs[6]  = '{64'h1, 7'd127, 1'b0, 32'h0, 1'b1};
        vecs[7]  = '{64'h0, 7'd127, 1'b1, 32'h0, 1'b0};
        vecs[8]  = '{64'h0000_0001_0000_0000, 7'd33, 1'b1, 32'h1, 1'b1};
        vecs[9]  = '{64'hABCD_0000_0000_0000, 7'd48, 1'b1, 32'h0000_ABCD, 1'b0};
        vecs[10] = '{64'h8000_0000_0000_0001, 7'd63, 1'b0, 32'h1, 1'b1};

        // Reset state
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Directed vectors, one at a time
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].data, vecs[i].shamt, vecs[i].jam);
            cur_exp_d = vecs[i].exp_data;
            cur_exp_s = vecs[i].exp_sticky;
            got = 0;
            for (int t = 0; t < 20 && !got; t++) cycle(got);
            check("vec_accept", got, 1);
            in_valid = 1'b0;
            drain(20);
        end

        // Back-to-back throughput with latency check
        check_lat = 1;
        for (int i = 0; i < 8; i++) begin
            drive({$urandom, $urandom}, 7'($urandom_range(0, 70)), 1'($urandom));
            cycle(got);
            check("tp_accept", got, 1);
        end
        in_valid = 1'b0;
        drain(20);
        check_lat = 0;

        // Backpressure: consumer stalls four cycles mid-stream
        for (int i = 0; i < 6; i++) begin
            bp_d[i] = {$urandom, $urandom};
            bp_s[i] = 7'($urandom_range(0, 66));
        end
        check_rdy = 1;
        base = n_drained;
        idx = 0;
        k = 0;
        while ((idx < 6 || sb.size() > 0) && k < 60) begin
            out_ready = !(k >= 2 && k < 6);
            if (idx < 6) drive(bp_d[idx], bp_s[idx], 1'(idx));
            else in_valid = 1'b0;
            cycle(got);
            if (got) idx++;
            k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_rdy = 0;
        check("bp_accepted", idx, 6);
        check("bp_delivered", n_drained - base, 6);
        drain(10);

        // Asynchronous reset with two transactions in flight
        out_ready = 1'b0;
        drive(64'h1234, 7'd4, 1'b0);
        cycle(got);
        drive(64'h5678, 7'd4, 1'b0);
        cycle(got);
        in_valid = 1'b0;
        #1;
        check("pre_reset_out_valid", out_valid, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_in_ready", in_ready, 1);
        sb.delete();
        held_valid = 0;
        @(negedge clk);
        nrst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(got);
            check("post_reset_idle", out_valid, 0);
        end
        #1;
        check("post_reset_in_ready", in_ready, 1);
        @(negedge clk);
        drive(64'hF2, 7'd2, 1'b1);
        cur_exp_d = 32'h3D;
        cur_exp_s = 1'b1;
        cycle(got);
        check("post_reset_accept", got, 1);
        in_valid = 1'b0;
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flp_vshrjam_pipe.md
Name: flp_vshrjam_pipe

Overview:
Pipelined, variable-amount shift-right-and-jam unit for the FLP datapath, used for mantissa alignment ahead of add/sub and for normalisation before rounding.
- Takes a per-transaction shift amount and a jam-enable bit.
- Shifts with a logarithmic shifter split across STAGES register stages.
- Returns a truncated result plus a separate sticky flag.
- Uses valid/ready handshakes on both sides and sustains full throughput under backpressure.

Parameters:
INWIDTH, 64, input operand width
OUTWIDTH, 32, result width (1 <= OUTWIDTH <= INWIDTH)
STAGES, 2, pipeline register stages (1 <= STAGES <= SHW)
SHW, $clog2(INWIDTH+1), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  unit accepts input this cycle
in_data  in  INWIDTH  operand
in_shamt  in  SHW  right-shift amount
in_jam  in  1  1: OR sticky into result LSB; 0: plain truncating shift
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OUTWIDTH  shifted, optionally jammed result
out_sticky  out  1  OR of all bits shifted out below result bit 0

Behaviour:
- Reset: one clock, clk; reset nrst is asynchronous and active-low. While nrst=0, all stage valid bits clear, so out_valid=0. in_ready=1 once the pipeline is empty.
- Data registers are not reset. Their values are don't-care while the corresponding valid bit is 0.
- Function:
  - sh = (in_data >> in_shamt)[OUTWIDTH-1:0]. Bits above OUTWIDTH after the shift are discarded, never jammed.
  - sticky = OR of in_data[min(in_shamt,INWIDTH)-1:0]; sticky=0 when in_shamt=0.
  - out_data = {sh[OUTWIDTH-1:1], sh[0] | (in_jam & sticky)}.
  - out_sticky = sticky, independent of in_jam.
- Saturation: in_shamt >= INWIDTH gives sh=0, sticky=|in_data, out_data = {0.., in_jam & sticky}.
- Shifter structure:
  - Level k (k=0..SHW-1) shifts by 2^k when in_shamt[k]=1.
  - Level k is placed in stage floor(k*STAGES/SHW).
  - Each level ORs its shifted-out bits into a running sticky that is carried between stages.
  - Residual shamt bits and in_jam are carried between stages.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready at edge) to out_valid, when there are no stalls.
- Handshake:
  - Stage i loads when it is empty or when stage i+1 loads/drains in the same cycle.
  - The last stage drains when out_valid & out_ready.
  - in_ready = !v[0] | load_en[1]; load_en[1] is driven by stage 1, or by out_ready for STAGES=1. This is a bubble-collapsing chain.
  - in_ready must not depend on in_valid.
- Throughput: 1 result per cycle while out_ready=1.
- Stall:
  - out_valid=1 & out_ready=0 holds out_data/out_sticky stable.
  - Upstream bubbles fill until all STAGES registers are valid, then in_ready=0.
  - A stall never drops or duplicates a transaction.
- Simultaneous accept and drain on a full pipeline: permitted, and occupancy stays at STAGES.
- Once out_valid rises it stays high until the transfer completes, and out_data does not change meanwhile.
- Reset mid-operation: in-flight transactions are discarded and out_valid falls asynchronously. No stale result appears after nrst rises.
- Ordering: strictly FIFO.

Decomposition:
- Shared FLP package (flp_pkg) holds the common constants and helper functions: the shift-width helper (clog2-based SHW computation) and the level-to-stage mapping function.
- One natural sub-module, flp_vshrjam_stage. It is combinational and covers a parametrised group of shifter levels (FIRST_LVL, NUM_LVL). It takes data, shamt, and sticky in, and produces shifted data, updated sticky, and passthrough shamt.
- Top level instantiates flp_vshrjam_stage STAGES times and owns the valid/ready registers plus the final jam/truncate.

Test Plan:
1. Defaults (64/32/2). in_data=64'hF2, in_shamt=2, in_jam=1 -> out_data=32'h3D, out_sticky=1. Repeat with in_jam=0 -> 32'h3C, sticky=1. in_data=64'hF4, in_shamt=2 -> 32'h3D, sticky=0.
2. Upper truncation. in_data=64'hFFFF_FFFF_1234_5678, in_shamt=0 -> 32'h1234_5678, sticky=0. in_data=64'h8000_0000_0000_0000, in_shamt=32 -> 32'h8000_0000, sticky=0.
3. Saturation.
   - in_data=1, in_shamt=64, jam=1 -> out_data=1, sticky=1.
   - in_data=1, in_shamt=127, jam=0 -> out_data=0, sticky=1.
   - in_data=0, in_shamt=127 -> out_data=0, sticky=0.
4. Throughput. out_ready=1; 8 back-to-back transactions with random data/shamt -> out_valid exactly 2 cycles after each accept, 8 consecutive results matching a reference model.
5. Backpressure. Stream 6 transactions, with out_ready=0 for 4 cycles mid-stream -> in_ready=0 once 2 items are held, out_data stable during the stall, all 6 results in order, none lost or duplicated.
6. Reset mid-flight. Drop nrst asynchronously (mid-cycle) with 2 transactions in flight -> out_valid=0 immediately. After release: no output until new input, then in_ready=1.
